// File: rtl/hazard_unit.sv
// Stall/forwarding control for a five-stage MIPS pipeline using the Tuse/Tnew model.
// Build option: HAZARD_FWD_EN enables forwarding; without it the unit is a pure interlock.
module hazard_unit #(
   parameter int CNT_W = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [4:0]       D_Rs_In,
   input  logic [4:0]       D_Rt_In,
   input  logic [1:0]       D_Tuse_Rs_In,
   input  logic [1:0]       D_Tuse_Rt_In,
   input  logic [1:0]       D_Tnew_In,
   input  logic [4:0]       D_Dst_In,
   input  logic             D_RegWrite_In,
   output logic             Stall_Out,
   output logic [1:0]       Fwd_Rs_D_Out,
   output logic [1:0]       Fwd_Rt_D_Out,
   output logic [1:0]       Fwd_Rs_E_Out,
   output logic [1:0]       Fwd_Rt_E_Out,
   output logic [1:0]       Fwd_Rt_M_Out,
   output logic [CNT_W-1:0] Stall_Cnt_Out
);

`ifdef HAZARD_FWD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   // Register $0 never produces a hazard, so a zero source can never match.
   function automatic logic f_hit(input logic we, input logic [4:0] dst, input logic [4:0] r);
      return we && (dst == r) && (r != 5'd0);
   endfunction

   function automatic logic [1:0] f_dec(input logic [1:0] tnew);
      return (tnew == 2'd0) ? 2'd0 : (tnew - 2'd1);
   endfunction

   // Youngest ready stage wins: E=1, M=2, W=3, none=0.
   function automatic logic [1:0] f_pick(input logic e_ok, input logic m_ok, input logic w_ok);
      logic [1:0] sel;
      if (e_ok) begin
         sel = 2'd1;
      end else if (m_ok) begin
         sel = 2'd2;
      end else if (w_ok) begin
         sel = 2'd3;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   logic [4:0]       r_e_dst, r_e_rs, r_e_rt, r_m_dst, r_m_rt, r_w_dst;
   logic             r_e_we, r_m_we, r_w_we;
   logic [1:0]       r_e_tnew, r_m_tnew, r_w_tnew;
   logic [CNT_W-1:0] r_cnt;

   logic w_rs_used, w_rt_used;
   logic w_rs_e, w_rs_m, w_rs_w, w_rt_e, w_rt_m, w_rt_w;
   logic w_ers_m, w_ers_w, w_ert_m, w_ert_w, w_mrt_w;
   logic w_stall;

   assign w_rs_used = (D_Tuse_Rs_In != 2'd3);
   assign w_rt_used = (D_Tuse_Rt_In != 2'd3);
   assign w_rs_e    = f_hit(r_e_we, r_e_dst, D_Rs_In);
   assign w_rs_m    = f_hit(r_m_we, r_m_dst, D_Rs_In);
   assign w_rs_w    = f_hit(r_w_we, r_w_dst, D_Rs_In);
   assign w_rt_e    = f_hit(r_e_we, r_e_dst, D_Rt_In);
   assign w_rt_m    = f_hit(r_m_we, r_m_dst, D_Rt_In);
   assign w_rt_w    = f_hit(r_w_we, r_w_dst, D_Rt_In);
   assign w_ers_m   = f_hit(r_m_we, r_m_dst, r_e_rs);
   assign w_ers_w   = f_hit(r_w_we, r_w_dst, r_e_rs);
   assign w_ert_m   = f_hit(r_m_we, r_m_dst, r_e_rt);
   assign w_ert_w   = f_hit(r_w_we, r_w_dst, r_e_rt);
   assign w_mrt_w   = f_hit(r_w_we, r_w_dst, r_m_rt);

   // Stall decision and forwarding selects from the D inputs and shadow stages.
   always_comb begin
      w_stall      = 1'b0;
      Fwd_Rs_D_Out = 2'd0;
      Fwd_Rt_D_Out = 2'd0;
      Fwd_Rs_E_Out = 2'd0;
      Fwd_Rt_E_Out = 2'd0;
      Fwd_Rt_M_Out = 2'd0;
      if (FWD_EN) begin
         w_stall = (w_rs_used && ((w_rs_e && (r_e_tnew > D_Tuse_Rs_In)) ||
                                  (w_rs_m && (r_m_tnew > D_Tuse_Rs_In)))) ||
                   (w_rt_used && ((w_rt_e && (r_e_tnew > D_Tuse_Rt_In)) ||
                                  (w_rt_m && (r_m_tnew > D_Tuse_Rt_In))));
         Fwd_Rs_D_Out = f_pick(w_rs_e && (r_e_tnew == 2'd0),
                               w_rs_m && (r_m_tnew == 2'd0),
                               w_rs_w && (r_w_tnew == 2'd0));
         Fwd_Rt_D_Out = f_pick(w_rt_e && (r_e_tnew == 2'd0),
                               w_rt_m && (r_m_tnew == 2'd0),
                               w_rt_w && (r_w_tnew == 2'd0));
         Fwd_Rs_E_Out = f_pick(1'b0, w_ers_m && (r_m_tnew == 2'd0), w_ers_w && (r_w_tnew == 2'd0));
         Fwd_Rt_E_Out = f_pick(1'b0, w_ert_m && (r_m_tnew == 2'd0), w_ert_w && (r_w_tnew == 2'd0));
         Fwd_Rt_M_Out = f_pick(1'b0, 1'b0, w_mrt_w && (r_w_tnew == 2'd0));
      end else begin
         // The regfile is only valid once W has written, so any pending writer blocks.
         w_stall = (w_rs_used && (w_rs_e || w_rs_m || w_rs_w)) ||
                   (w_rt_used && (w_rt_e || w_rt_m || w_rt_w));
      end
   end

   // Shadow pipeline advance and saturating stall counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_e_dst  <= 5'd0;
         r_e_rs   <= 5'd0;
         r_e_rt   <= 5'd0;
         r_e_we   <= 1'b0;
         r_e_tnew <= 2'd0;
         r_m_dst  <= 5'd0;
         r_m_rt   <= 5'd0;
         r_m_we   <= 1'b0;
         r_m_tnew <= 2'd0;
         r_w_dst  <= 5'd0;
         r_w_we   <= 1'b0;
         r_w_tnew <= 2'd0;
         r_cnt    <= {CNT_W{1'b0}};
      end else begin
         if (w_stall) begin
            r_e_dst  <= 5'd0;
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_e_we   <= 1'b0;
            r_e_tnew <= 2'd0;
         end else begin
            r_e_dst  <= D_Dst_In;
            r_e_rs   <= D_Rs_In;
            r_e_rt   <= D_Rt_In;
            r_e_we   <= D_RegWrite_In;
            r_e_tnew <= D_Tnew_In;
         end
         r_m_dst  <= r_e_dst;
         r_m_rt   <= r_e_rt;
         r_m_we   <= r_e_we;
         r_m_tnew <= f_dec(r_e_tnew);
         r_w_dst  <= r_m_dst;
         r_w_we   <= r_m_we;
         r_w_tnew <= f_dec(r_m_tnew);
         if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   assign Stall_Out     = w_stall;
   assign Stall_Cnt_Out = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit against an age-based instruction model.
module tb_hazard_unit;
   logic        Clk, Reset;
   logic [4:0]  D_Rs_In, D_Rt_In, D_Dst_In;
   logic [1:0]  D_Tuse_Rs_In, D_Tuse_Rt_In, D_Tnew_In;
   logic        D_RegWrite_In;
   logic        Stall_Out;
   logic [1:0]  Fwd_Rs_D_Out, Fwd_Rt_D_Out, Fwd_Rs_E_Out, Fwd_Rt_E_Out, Fwd_Rt_M_Out;
   logic [31:0] Stall_Cnt_Out;

   hazard_unit #(.CNT_W(32)) dut (
      .Clk(Clk), .Reset(Reset),
      .D_Rs_In(D_Rs_In), .D_Rt_In(D_Rt_In),
      .D_Tuse_Rs_In(D_Tuse_Rs_In), .D_Tuse_Rt_In(D_Tuse_Rt_In),
      .D_Tnew_In(D_Tnew_In), .D_Dst_In(D_Dst_In), .D_RegWrite_In(D_RegWrite_In),
      .Stall_Out(Stall_Out),
      .Fwd_Rs_D_Out(Fwd_Rs_D_Out), .Fwd_Rt_D_Out(Fwd_Rt_D_Out),
      .Fwd_Rs_E_Out(Fwd_Rs_E_Out), .Fwd_Rt_E_Out(Fwd_Rt_E_Out),
      .Fwd_Rt_M_Out(Fwd_Rt_M_Out), .Stall_Cnt_Out(Stall_Cnt_Out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   int n_err = 0;
   int n_chk = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: each in-flight instruction remembers when it entered E; remaining latency is
   // its Tnew minus its age, floored at zero. Index 0 = E, 1 = M, 2 = W.
   typedef struct { int dst; bit we; int tnew; int born; int rs; int rt; } ins_t;
   ins_t   stg[3];
   int     cyc = 0;
   longint m_cnt = 0;
   bit     e_stall;
   int     e_fd_rs, e_fd_rt, e_fe_rs, e_fe_rt, e_fm_rt;
   bit     obs_stall;

   function automatic ins_t bubble();
      ins_t b;
      b.dst = 0; b.we = 1'b0; b.tnew = 0; b.born = 0; b.rs = 0; b.rt = 0;
      return b;
   endfunction

   function automatic int rem(int k);
      int v;
      v = stg[k].tnew - (cyc - stg[k].born);
      return (v < 0) ? 0 : v;
   endfunction

   function automatic bit live(int k, int r);
      return stg[k].we && (stg[k].dst == r) && (r != 0);
   endfunction

   function automatic bit op_stall(int r, int tuse);
      if (tuse == 3 || r == 0) return 1'b0;
      if (FWD) return (live(0, r) && rem(0) > tuse) || (live(1, r) && rem(1) > tuse);
      return live(0, r) || live(1, r) || live(2, r);
   endfunction

   function automatic int dsel(int r, int first);
      if (!FWD) return 0;
      for (int k = first; k < 3; k++)
         if (live(k, r) && rem(k) == 0) return k + 1;
      return 0;
   endfunction

   task automatic model_eval();
      e_stall = op_stall(int'(D_Rs_In), int'(D_Tuse_Rs_In)) ||
                op_stall(int'(D_Rt_In), int'(D_Tuse_Rt_In));
      e_fd_rs = dsel(int'(D_Rs_In), 0);
      e_fd_rt = dsel(int'(D_Rt_In), 0);
      e_fe_rs = dsel(stg[0].rs, 1);
      e_fe_rt = dsel(stg[0].rt, 1);
      e_fm_rt = dsel(stg[1].rt, 2);
   endtask

   task automatic model_advance();
      ins_t n;
      cyc++;
      if (Reset) begin
         for (int k = 0; k < 3; k++) stg[k] = bubble();
         m_cnt = 0;
      end else begin
         if (e_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         stg[2] = stg[1];
         stg[1] = stg[0];
         n = bubble();
         if (!e_stall) begin
            n.dst = int'(D_Dst_In); n.we = D_RegWrite_In; n.tnew = int'(D_Tnew_In);
            n.rs = int'(D_Rs_In); n.rt = int'(D_Rt_In);
         end
         n.born = cyc;
         stg[0] = n;
      end
   endtask

   // One clock: check at the falling edge, then advance the model at the rising edge.
   task automatic step();
      @(negedge Clk);
      model_eval();
      obs_stall = Stall_Out;
      check_val("stall", {31'd0, Stall_Out}, {31'd0, e_stall});
      check_val("fwd_rs_d", {30'd0, Fwd_Rs_D_Out}, e_fd_rs);
      check_val("fwd_rt_d", {30'd0, Fwd_Rt_D_Out}, e_fd_rt);
      check_val("fwd_rs_e", {30'd0, Fwd_Rs_E_Out}, e_fe_rs);
      check_val("fwd_rt_e", {30'd0, Fwd_Rt_E_Out}, e_fe_rt);
      check_val("fwd_rt_m", {30'd0, Fwd_Rt_M_Out}, e_fm_rt);
      check_val("stall_cnt", Stall_Cnt_Out, m_cnt[31:0]);
      @(posedge Clk);
      model_advance();
      #1;
   endtask

   task automatic drive(int dst, bit we, int tnew, int rs, int rt, int tu_rs, int tu_rt);
      D_Dst_In = dst[4:0]; D_RegWrite_In = we; D_Tnew_In = tnew[1:0];
      D_Rs_In = rs[4:0]; D_Rt_In = rt[4:0];
      D_Tuse_Rs_In = tu_rs[1:0]; D_Tuse_Rt_In = tu_rt[1:0];
   endtask

   // Issue one instruction, holding it in D while the pipeline stalls it.
   task automatic issue(int dst, bit we, int tnew, int rs, int rt, int tu_rs, int tu_rt);
      drive(dst, we, tnew, rs, rt, tu_rs, tu_rt);
      step();
      for (int i = 0; i < 5 && obs_stall; i++) step();
   endtask

   task automatic nops(int n);
      for (int i = 0; i < n; i++) issue(0, 1'b0, 0, 0, 0, 3, 3);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   int n_st;
   int exp_st;

   initial begin
      for (int k = 0; k < 3; k++) stg[k] = bubble();
      Reset = 1'b1;
      drive(0, 1'b0, 0, 0, 0, 3, 3);
      repeat (2) @(posedge Clk);
      #1;
      @(negedge Clk);
      check_val("rst_stall", {31'd0, Stall_Out}, 32'd0);
      check_val("rst_fwd", {22'd0, Fwd_Rs_D_Out, Fwd_Rt_D_Out, Fwd_Rs_E_Out,
                            Fwd_Rt_E_Out, Fwd_Rt_M_Out}, 32'd0);
      check_val("rst_cnt", Stall_Cnt_Out, 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      // lw $1 ; add $2,$1,$3 -- count the stall cycles seen on the DUT.
      exp_st = FWD ? 1 : 3;
      drive(1, 1'b1, 2, 0, 0, 3, 3);
      step();
      drive(2, 1'b1, 1, 1, 3, 1, 1);
      n_st = 0;
      step();
      for (int i = 0; i < 6 && obs_stall; i++) begin
         n_st++;
         step();
      end
      check_val("lw_add_stalls", n_st, exp_st);
      check_val("lw_add_cnt", Stall_Cnt_Out, exp_st);
      nops(3);

      issue(1, 1'b1, 1, 0, 0, 3, 3);    // add $1
      issue(0, 1'b0, 0, 1, 4, 0, 0);    // beq $1,$4
      nops(3);
      issue(31, 1'b1, 1, 0, 0, 3, 3);   // jal
      issue(0, 1'b0, 0, 31, 0, 0, 3);   // jr $31
      nops(3);
      issue(5, 1'b1, 1, 0, 0, 3, 3);    // add $5
      issue(0, 1'b0, 0, 6, 5, 1, 2);    // sw $5,0($6)
      nops(3);
      issue(0, 1'b1, 2, 0, 0, 3, 3);    // lw $0
      issue(2, 1'b1, 1, 0, 0, 1, 1);    // add $2,$0,$0
      nops(3);

      // Reset in the middle of a load-use stall.
      drive(1, 1'b1, 2, 0, 0, 3, 3);
      step();
      drive(2, 1'b1, 1, 1, 3, 1, 1);
      step();
      do_reset();
      step();
      check_val("midrst_cnt", Stall_Cnt_Out, 32'd0);
      nops(2);

      // Random traffic on a small register set so hazards are frequent.
      for (int i = 0; i < 600; i++) begin
         if (!obs_stall) begin
            drive($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
         end
         Reset = ($urandom_range(0, 39) == 0);
         step();
      end
      Reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
